// File: rtl/fifo_flow_ctrl_if.sv
// Bundle of the FIFO push/pop handshake, runtime thresholds and status outputs.
//
// Parameters
//   DATA_SIZE  word width in bits
//   ADDR_SIZE  log2 of the FIFO depth; count and threshold fields are ADDR_SIZE+1 bits
//
// Modports
//   master  the agent that pushes/pops and sets thresholds (upstream source / arbiter side)
//   slave   the FIFO itself
//
// Signals
//   write, read         push / pop requests
//   data_in_push        push data
//   almost_full_in      pause-entry threshold, in entries
//   almost_empty_in     pause-exit threshold, in entries
//   data_out_pop        registered popped word
//   fifo_count          occupancy 0..DEPTH
//   fifo_empty/full     occupancy at 0 / at DEPTH
//   fifo_almost_full    occupancy >= almost_full_in
//   fifo_almost_empty   occupancy <= almost_empty_in
//   fifo_pause          flow-control request to the source
//   fifo_error          overflow/underflow indication
interface fifo_flow_ctrl_if #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3
);

    logic                 write;
    logic                 read;
    logic [DATA_SIZE-1:0] data_in_push;
    logic [ADDR_SIZE:0]   almost_full_in;
    logic [ADDR_SIZE:0]   almost_empty_in;

    logic [DATA_SIZE-1:0] data_out_pop;
    logic [ADDR_SIZE:0]   fifo_count;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_almost_full;
    logic                 fifo_almost_empty;
    logic                 fifo_pause;
    logic                 fifo_error;

    modport master (
        output write,
        output read,
        output data_in_push,
        output almost_full_in,
        output almost_empty_in,
        input  data_out_pop,
        input  fifo_count,
        input  fifo_empty,
        input  fifo_full,
        input  fifo_almost_full,
        input  fifo_almost_empty,
        input  fifo_pause,
        input  fifo_error
    );

    modport slave (
        input  write,
        input  read,
        input  data_in_push,
        input  almost_full_in,
        input  almost_empty_in,
        output data_out_pop,
        output fifo_count,
        output fifo_empty,
        output fifo_full,
        output fifo_almost_full,
        output fifo_almost_empty,
        output fifo_pause,
        output fifo_error
    );

endinterface

// File: rtl/fifo_flow_ctrl.sv
// Parametrised synchronous FIFO with hysteretic flow-control pause.
//
// Sits between a lane producer and the switch arbiter. Words are DATA_SIZE bits, depth is
// 2**ADDR_SIZE. Runtime almost-full / almost-empty thresholds drive the status flags and a
// two-state pause FSM whose registered output throttles the upstream source.
//
// Ports
//   clk     single clock, all state on the rising edge
//   reset   asynchronous, active-high; clears pointers, output word, pause FSM and error
//   bus     fifo_flow_ctrl_if.slave: push/pop handshake, thresholds and status (see interface)
//
// Compile-time option
//   FIFO_ERR_STICKY_EN  undefined: fifo_error pulses for one cycle per rejected operation.
//                       defined:   fifo_error latches on the first rejected operation and stays
//                                  high until reset; FIFO operation carries on regardless.
module fifo_flow_ctrl #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3
) (
    input  logic              clk,
    input  logic              reset,
    fifo_flow_ctrl_if.slave   bus
);

    localparam int unsigned        Depth    = 1 << ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] DepthCnt = (ADDR_SIZE + 1)'(Depth);

    typedef enum logic {
        StRun,
        StPause
    } state_e;

    // Storage is deliberately not reset; only the pointers define which entries are valid.
    logic [DATA_SIZE-1:0] mem [Depth];

    // Pointers carry one extra bit so full (difference == Depth) and empty (difference == 0)
    // are distinguishable with natural wrap.
    logic [ADDR_SIZE:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_SIZE-1:0] wr_addr, rd_addr;
    logic [ADDR_SIZE:0]   count, count_next;

    logic                 rd_ok, wr_ok, err_evt;
    logic                 err_q, err_d;
    logic [DATA_SIZE-1:0] dout_q, dout_d;
    state_e               state_q, state_d;

    // ------------------------------------------------------------------------------------
    // Acceptance and next-state datapath
    // ------------------------------------------------------------------------------------
    always_comb begin
        count   = wr_ptr_q - rd_ptr_q;
        wr_addr = wr_ptr_q[ADDR_SIZE-1:0];
        rd_addr = rd_ptr_q[ADDR_SIZE-1:0];

        // Read depends only on registered occupancy: no fall-through of a same-cycle write.
        rd_ok   = bus.read && (count != '0);
        // A full FIFO still takes a write when a read frees a slot at the same edge.
        wr_ok   = bus.write && ((count != DepthCnt) || rd_ok);
        err_evt = (bus.write && !wr_ok) || (bus.read && !rd_ok);

        wr_ptr_d   = wr_ptr_q + (ADDR_SIZE + 1)'(wr_ok);
        rd_ptr_d   = rd_ptr_q + (ADDR_SIZE + 1)'(rd_ok);
        count_next = wr_ptr_d - rd_ptr_d;

        dout_d = dout_q;
        if (rd_ok) begin
            dout_d = mem[rd_addr];
        end

`ifdef FIFO_ERR_STICKY_EN
        err_d = err_q | err_evt;
`else
        err_d = err_evt;
`endif
    end

    // ------------------------------------------------------------------------------------
    // Pause FSM next state. Entry is tested first so equal or inverted thresholds settle in
    // PAUSE instead of oscillating; exit additionally requires being below the entry point.
    // ------------------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (count_next >= bus.almost_full_in) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if ((count_next <= bus.almost_empty_in) &&
                    (count_next < bus.almost_full_in)) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // ------------------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            dout_q   <= '0;
            err_q    <= 1'b0;
            state_q  <= StRun;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            dout_q   <= dout_d;
            err_q    <= err_d;
            state_q  <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= bus.data_in_push;
        end
    end

    // ------------------------------------------------------------------------------------
    // Outputs: flags are combinational from registered count and live thresholds
    // ------------------------------------------------------------------------------------
    assign bus.data_out_pop      = dout_q;
    assign bus.fifo_count        = count;
    assign bus.fifo_empty        = (count == '0);
    assign bus.fifo_full         = (count == DepthCnt);
    assign bus.fifo_almost_full  = (count >= bus.almost_full_in);
    assign bus.fifo_almost_empty = (count <= bus.almost_empty_in);
    assign bus.fifo_pause        = (state_q == StPause);
    assign bus.fifo_error        = err_q;

endmodule
